branch_predictor_unit: RTL

Parametrised next-generation fetch-stage predictor: a direct-mapped BHT of saturating counters plus a fully associative, valid-tagged BTB with typed entries and optional return-address stack. Sits beside the IF-stage PC mux. Lookup is combinational on the current fetch PC; training comes from the ID stage one or more cycles later.

---
 rtl/bpu_pkg.sv | 30 +++
 rtl/branch_predictor_unit_if.sv | 35 +++
 rtl/bpu_ras.sv | 64 ++++++
 rtl/branch_predictor_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Branch predictor shared definitions.
// Holds the BTB entry kind encoding, the BTB entry record, and the helper
// functions for the counter reset value and the table index widths.
// Used by branch_predictor_unit and bpu_ras through import bpu_pkg::*.
package bpu_pkg;

  typedef enum logic [1:0] {
    KIND_COND = 2'd0,
    KIND_JUMP = 2'd1,
    KIND_RET  = 2'd2
  } bpu_kind_e;

  typedef struct packed {
    logic      valid;
    logic [31:0] tag;
    logic [31:0] target;
    bpu_kind_e kind;
  } btb_entry_t;

  // Number of index bits for a table of n entries (never below 1).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Weakly not-taken: one step below the taken threshold.
  function automatic int ctr_reset_val(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_unit_if.sv
// Fetch/decode side bus of the branch predictor.
// Signals: if_pc/if_pc_4 (fetch PC and PC+4), id_* (training from decode),
// pred_hit/pred_taken/pred_pc (lookup result).
// Modports: master = pipeline side, slave = predictor.
// Handshake: there is no valid/ready pair. id_valid is a single-cycle
// strobe with no backpressure; every id_* field is sampled on the rising
// clock edge where id_valid is high and ignored otherwise. The pred_*
// outputs are combinational and always valid for the current if_pc.
interface branch_predictor_unit_if;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_target;
  logic        id_is_branch;
  logic        id_is_jump;
  logic        id_is_call;
  logic        id_is_ret;
  logic        id_taken;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_pc;

  modport master (
    output if_pc, if_pc_4, id_valid, id_pc, id_target, id_is_branch,
           id_is_jump, id_is_call, id_is_ret, id_taken,
    input  pred_hit, pred_taken, pred_pc
  );

  modport slave (
    input  if_pc, if_pc_4, id_valid, id_pc, id_target, id_is_branch,
           id_is_jump, id_is_call, id_is_ret, id_taken,
    output pred_hit, pred_taken, pred_pc
  );
endinterface

// File: rtl/bpu_ras.sv
// Circular return-address stack.
// Ports: clk, rst (async, active-high), push_i, pop_i, push_data_i,
// top_o (entry at the top pointer), empty_o (count is zero).
// Push and pop together replace the top entry without moving the pointer.
// A push onto a full stack overwrites the oldest entry; count saturates.
module bpu_ras #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_data_i,
  output logic [31:0] top_o,
  output logic        empty_o
);
  import bpu_pkg::*;

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] tp_q, tp_d, wr_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = tp_q;
    if (push_i && pop_i) begin
      wr_en = 1'b1;
    end else if (push_i) begin
      tp_d   = (tp_q == PTR_LAST) ? '0 : tp_q + 1'b1;
      wr_ptr = tp_d;
      wr_en  = 1'b1;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && cnt_q != '0) begin
      tp_d  = (tp_q == '0) ? PTR_LAST : tp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is read while the count is zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= push_data_i;
  end

  assign top_o   = mem_q[tp_q];
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/branch_predictor_unit.sv
// Fetch-stage branch predictor: direct-mapped BHT of saturating counters
// plus a fully associative BTB with typed entries (COND/JUMP/RET).
// Ports: clk, rst (async, active-high), bus (branch_predictor_unit_if.slave),
// repl_ptr_o (BTB replacement pointer, debug view).
// Optional feature macro: BPU_RAS_EN adds a return-address stack that
// supplies the target of RET-kind hits; without it RET behaves as JUMP.
module branch_predictor_unit
  import bpu_pkg::*;
#(
  parameter int BHT_ENTRIES = 256,
  parameter int BTB_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int RAS_DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  branch_predictor_unit_if.slave         bus,
  output logic [idx_width(BTB_ENTRIES)-1:0] repl_ptr_o
);

  localparam int BHT_IW = idx_width(BHT_ENTRIES);
  localparam int PTR_W  = idx_width(BTB_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  btb_entry_t          btb_q [BTB_ENTRIES];
  logic [CTR_BITS-1:0] bht_q [BHT_ENTRIES];
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  // ---------------- lookup ----------------
  logic        hit;
  btb_entry_t  hit_e;
  logic        ctr_msb;
  logic        taken;
  logic [31:0] redirect;
  logic [31:0] ras_top;
  logic        ras_empty;

  always_comb begin
    hit   = 1'b0;
    hit_e = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (btb_q[i].valid && btb_q[i].tag == bus.if_pc) begin
        hit   = 1'b1;
        hit_e = btb_q[i];
      end
    end
  end

  assign ctr_msb = bht_q[bus.if_pc[BHT_IW+1:2]][CTR_BITS-1];

  always_comb begin
    taken    = 1'b0;
    redirect = hit_e.target;
    if (hit) begin
      taken = (hit_e.kind == KIND_COND) ? ctr_msb : 1'b1;
      if (hit_e.kind == KIND_RET && !ras_empty) redirect = ras_top;
    end
  end

  assign bus.pred_hit   = hit;
  assign bus.pred_taken = taken;
  assign bus.pred_pc    = taken ? redirect : bus.if_pc_4;
  assign repl_ptr_o     = ptr_q;

  // ---------------- training ----------------
  logic             id_match, free_found, wr_en, evict, ctr_en;
  logic [PTR_W-1:0] match_idx, free_idx, wr_idx;
  bpu_kind_e        wr_kind;
  logic [BHT_IW-1:0]   id_idx;
  logic [CTR_BITS-1:0] ctr_d;

  always_comb begin
    id_match   = 1'b0;
    match_idx  = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (btb_q[i].valid && btb_q[i].tag == bus.id_pc) begin
        id_match  = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
    // Scan downward so the lowest free index is the one left standing.
    for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
      if (!btb_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end
    end
  end

  // A call always carries id_is_jump too; folding it in keeps a call that
  // arrives without the jump flag from being dropped.
  assign wr_en = bus.id_valid & (bus.id_is_jump | bus.id_is_call | bus.id_is_ret |
                                 (bus.id_is_branch & bus.id_taken));
  assign wr_kind = bus.id_is_ret ? KIND_RET :
                   (bus.id_is_jump | bus.id_is_call) ? KIND_JUMP : KIND_COND;
  assign wr_idx  = id_match ? match_idx : (free_found ? free_idx : ptr_q);
  assign evict   = wr_en & ~id_match & ~free_found;
  assign ptr_d   = evict ? ptr_q + 1'b1 : ptr_q;

  assign id_idx = bus.id_pc[BHT_IW+1:2];
  assign ctr_en = bus.id_valid & bus.id_is_branch;

  always_comb begin
    ctr_d = bht_q[id_idx];
    if (bus.id_taken) begin
      if (ctr_d != CTR_MAX) ctr_d = ctr_d + 1'b1;
    end else begin
      if (ctr_d != '0) ctr_d = ctr_d - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_RST;
      ptr_q <= '0;
    end else begin
      if (wr_en) begin
        btb_q[wr_idx] <= '{valid: 1'b1, tag: bus.id_pc,
                           target: bus.id_target, kind: wr_kind};
      end
      if (ctr_en) bht_q[id_idx] <= ctr_d;
      ptr_q <= ptr_d;
    end
  end

`ifdef BPU_RAS_EN
  bpu_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.id_valid & bus.id_is_call),
    .pop_i       (bus.id_valid & bus.id_is_ret),
    .push_data_i (bus.id_pc + 32'd4),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
`endif

endmodule
